// File: rtl/mem_stream_responder_pkg.sv
// Shared types and constants for the memory stream responder.
package mem_resp_pkg;

    localparam logic [31:0] BAD_WORD   = 32'hDEADBEEF;
    localparam logic [63:0] WORD_BYTES = 64'd4;

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_BEAT, R_ACK} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_LAT, W_BEAT, W_ACK} wr_state_t;

    // Misaligned, beyond the array, or a stride other than one word.
    function automatic logic addr_bad(input logic [63:0] addr, input logic [63:0] size, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 64'd0) || (size != WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_stream_responder_if.sv
// Streaming read/write request bus between accelerator (master) and memory (slave).
interface mem_stream_responder_if;
    logic        read_enable;
    logic [63:0] read_addr;
    logic [63:0] read_size;
    logic        finish_read;
    logic [63:0] read_ready;
    logic [31:0] read_data;
    logic        write_enable;
    logic [63:0] write_addr;
    logic [63:0] write_size;
    logic [31:0] write_data;
    logic        finish_write;
    logic [63:0] write_ready;

    modport master (
        output read_enable, read_addr, read_size, finish_read,
        output write_enable, write_addr, write_size, write_data, finish_write,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_enable, read_addr, read_size, finish_read,
        input  write_enable, write_addr, write_size, write_data, finish_write,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/mem_stream_responder_ram.sv
// Word array with one registered read port and one write port.
// Latency: read data one cycle after rd_en; write lands at the edge.
// Backpressure: none; same-edge read and write to one index returns the old word.
module mem_resp_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];

    // Contents deliberately survive reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rd_data <= 32'd0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_stream_responder.sv
// Memory-side responder serving stream word reads/writes plus a host preload port.
// Latency: beat READ_LAT+1 / WRITE_LAT+1 cycles after the request or finish edge.
// Backpressure: one beat in flight per channel; host access refused unless both channels idle.
module mem_stream_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_stream_responder_if.slave  s,
    input  logic                   host_en,
    input  logic                   host_we,
    input  logic [AW-1:0]          host_addr,
    input  logic [31:0]            host_wdata,
    output logic [31:0]            host_rdata,
    output logic                   host_busy,
    output logic                   err,
    output logic [31:0]            rd_words,
    output logic [31:0]            wr_words
);

    rd_state_t     rd_state, rd_next;
    wr_state_t     wr_state, wr_next;
    logic [3:0]    rd_cnt, wr_cnt;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          rd_bad, wr_bad;
    logic          rd_latch, rd_fetch, rd_beat;
    logic          wr_latch, wr_commit, wr_beat;
    logic          host_ok;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [31:0]   ram_rd_data, ram_wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (s.read_enable) rd_next = R_LAT;
            R_LAT:   if (rd_cnt == 4'd0) rd_next = R_BEAT;
            R_BEAT:  rd_next = R_ACK;
            R_ACK:   if (!s.read_enable) rd_next = R_IDLE;
                     else if (s.finish_read) rd_next = R_LAT;
            default: rd_next = R_IDLE;
        endcase
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (s.write_enable) wr_next = W_LAT;
            W_LAT:   if (wr_cnt == 4'd0) wr_next = W_BEAT;
            W_BEAT:  wr_next = W_ACK;
            W_ACK:   if (!s.write_enable) wr_next = W_IDLE;
                     else if (s.finish_write) wr_next = W_LAT;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_latch  = (rd_state == R_IDLE && s.read_enable) ||
                    (rd_state == R_ACK && s.read_enable && s.finish_read);
        rd_fetch  = (rd_state == R_LAT) && (rd_cnt == 4'd0);
        rd_beat   = (rd_state == R_BEAT);
        wr_latch  = (wr_state == W_IDLE && s.write_enable) ||
                    (wr_state == W_ACK && s.write_enable && s.finish_write);
        wr_commit = (wr_state == W_LAT) && (wr_cnt == 4'd0);
        wr_beat   = (wr_state == W_BEAT);
        host_ok   = host_en && (rd_state == R_IDLE) && (wr_state == W_IDLE);
        host_busy = host_en && !host_ok;
    end

    // Stream accesses only occur outside idle and host accesses only in idle,
    // so the ports never see both at once.
    always_comb begin
        ram_rd_en   = rd_fetch || (host_ok && !host_we);
        ram_rd_addr = rd_fetch ? rd_idx : host_addr;
        ram_wr_en   = (wr_commit && !wr_bad) || (host_ok && host_we);
        ram_wr_addr = wr_commit ? wr_idx : host_addr;
        ram_wr_data = wr_commit ? s.write_data : host_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt   <= 4'd0;
            wr_cnt   <= 4'd0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            rd_bad   <= 1'b0;
            wr_bad   <= 1'b0;
            rd_words <= 32'd0;
            wr_words <= 32'd0;
            err      <= 1'b0;
        end else begin
            if (rd_latch) begin
                rd_cnt <= 4'(READ_LAT);
                rd_idx <= s.read_addr[AW+1:2];
                rd_bad <= addr_bad(s.read_addr, s.read_size, AW);
            end else if (rd_state == R_LAT && rd_cnt != 4'd0) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (wr_latch) begin
                wr_cnt <= 4'(WRITE_LAT);
                wr_idx <= s.write_addr[AW+1:2];
                wr_bad <= addr_bad(s.write_addr, s.write_size, AW);
            end else if (wr_state == W_LAT && wr_cnt != 4'd0) begin
                wr_cnt <= wr_cnt - 4'd1;
            end
            if (rd_beat) rd_words <= rd_words + 32'd1;
            if (wr_beat) wr_words <= wr_words + 32'd1;
            if ((rd_fetch && rd_bad) || (wr_commit && wr_bad)) err <= 1'b1;
        end
    end

    assign s.read_ready  = {63'd0, rd_beat};
    assign s.write_ready = {63'd0, wr_beat};
    assign s.read_data   = rd_bad ? BAD_WORD : ram_rd_data;
    assign host_rdata    = ram_rd_data;

    mem_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

endmodule

// File: tb/tb_mem_stream_responder.sv
// Randomised bench for mem_stream_responder against a commit-time array model.
module tb_mem_stream_responder;

    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_en, host_we;
    logic [4:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_busy, err;
    logic [31:0] rd_words, wr_words;

    mem_stream_responder_if sif ();

    mem_stream_responder #(.DEPTH(32), .AW(5), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .s          (sif),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_busy  (host_busy),
        .err        (err),
        .rd_words   (rd_words),
        .wr_words   (wr_words)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: value, value before the latest write, and the edge of that write.
    logic [31:0] m_mem  [32];
    logic [31:0] m_prev [32];
    longint      m_wcyc [32];
    int          m_rd, m_wr;
    bit          m_err;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [63:0] a, input logic [63:0] sz);
        return (a[1:0] != 2'b00) || (a >= 64'd128) || (sz != 64'd4);
    endfunction

    task automatic read_burst(input logic [63:0] base, input int n, input logic [63:0] size);
        logic [63:0] a;
        logic [4:0]  idx;
        logic [31:0] exp;
        int          k;
        for (int i = 0; i < n; i++) begin
            a = base + 64'(4 * i);
            if (i == 0) begin
                @(negedge clk);
                sif.read_enable = 1'b1; sif.read_addr = a; sif.read_size = size;
                @(posedge clk);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                sif.read_addr = a; sif.finish_read = 1'b1;
                @(posedge clk);
                #1 sif.finish_read = 1'b0;
            end
            k = 0;
            do begin @(posedge clk); #1; k++; end while (sif.read_ready[0] !== 1'b1 && k < 20);
            chk("rd_lat", 64'(k), 64'(READ_LAT + 1));
            idx = a[6:2];
            if (is_bad(a, size)) begin
                exp = 32'hDEADBEEF; m_err = 1'b1;
            end else if (m_wcyc[idx] == cyc) exp = m_prev[idx];
            else exp = m_mem[idx];
            chk("rd_data", 64'(sif.read_data), 64'(exp));
            m_rd++;
            @(posedge clk);
            #1 chk("rd_gap", sif.read_ready, 64'd0);
        end
        @(negedge clk); sif.read_enable = 1'b0;
        @(posedge clk);
    endtask

    task automatic write_burst(input logic [63:0] base, input int n, input logic [63:0] size,
                               input logic [31:0] dbase, input bit rnd);
        logic [63:0] a;
        logic [4:0]  idx;
        logic [31:0] d;
        int          k;
        for (int i = 0; i < n; i++) begin
            a = base + 64'(4 * i);
            d = rnd ? $urandom : dbase + 32'(i);
            if (i == 0) begin
                @(negedge clk);
                sif.write_enable = 1'b1; sif.write_addr = a; sif.write_size = size; sif.write_data = d;
                @(posedge clk);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                sif.write_addr = a; sif.write_data = d; sif.finish_write = 1'b1;
                @(posedge clk);
                #1 sif.finish_write = 1'b0;
            end
            k = 0;
            do begin @(posedge clk); #1; k++; end while (sif.write_ready[0] !== 1'b1 && k < 20);
            chk("wr_lat", 64'(k), 64'(WRITE_LAT + 1));
            idx = a[6:2];
            if (is_bad(a, size)) m_err = 1'b1;
            else begin
                m_prev[idx] = m_mem[idx]; m_mem[idx] = d; m_wcyc[idx] = cyc;
            end
            m_wr++;
            @(posedge clk);
            #1 chk("wr_gap", sif.write_ready, 64'd0);
        end
        @(negedge clk); sif.write_enable = 1'b0;
        @(posedge clk);
    endtask

    task automatic host_access(input bit we, input logic [4:0] idx, input logic [31:0] d, input bit exp_busy);
        @(negedge clk);
        host_en = 1'b1; host_we = we; host_addr = idx; host_wdata = d;
        #1 chk("host_busy", 64'(host_busy), 64'(exp_busy));
        @(posedge clk);
        #1 host_en = 1'b0; host_we = 1'b0;
        if (!exp_busy) begin
            if (we) m_mem[idx] = d;
            else chk("host_rd", 64'(host_rdata), 64'(m_mem[idx]));
        end
    endtask

    task automatic chk_outputs_zero();
        chk("z_rready", sif.read_ready, 64'd0);
        chk("z_rdata", 64'(sif.read_data), 64'd0);
        chk("z_wready", sif.write_ready, 64'd0);
        chk("z_hrdata", 64'(host_rdata), 64'd0);
        chk("z_hbusy", 64'(host_busy), 64'd0);
        chk("z_err", 64'(err), 64'd0);
        chk("z_rdw", 64'(rd_words), 64'd0);
        chk("z_wrw", 64'(wr_words), 64'd0);
    endtask

    task automatic chk_counts();
        chk("rd_words", 64'(rd_words), 64'(m_rd));
        chk("wr_words", 64'(wr_words), 64'(m_wr));
        chk("err", 64'(err), 64'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        logic [63:0] rb, wb;
        reset = 1'b0;
        host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        sif.read_enable = 1'b0; sif.read_addr = '0; sif.read_size = 64'd4; sif.finish_read = 1'b0;
        sif.write_enable = 1'b0; sif.write_addr = '0; sif.write_size = 64'd4;
        sif.write_data = '0; sif.finish_write = 1'b0;
        for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_prev[i] = '0; m_wcyc[i] = -1; end
        m_rd = 0; m_wr = 0; m_err = 1'b0;
        #27;
        chk_outputs_zero();
        @(negedge clk) reset = 1'b1;

        // Preload: words 0..7 = 100..107, the rest random.
        for (int i = 0; i < 32; i++)
            host_access(1'b1, 5'(i), (i < 8) ? 32'(100 + i) : $urandom, 1'b0);
        host_access(1'b0, 5'd3, 32'd0, 1'b0);

        read_burst(64'h0, 8, 64'd4);
        chk_counts();

        write_burst(64'h40, 4, 64'd4, 32'hA0, 1'b0);
        for (int i = 16; i < 20; i++) host_access(1'b0, 5'(i), 32'd0, 1'b0);
        chk_counts();

        fork
            read_burst(64'h0, 8, 64'd4);
            write_burst(64'h0, 8, 64'd4, 32'd0, 1'b1);
        join
        chk_counts();

        read_burst(64'h82, 1, 64'd4);
        chk("err_misalign", 64'(err), 64'd1);
        write_burst(64'h1000, 1, 64'd4, 32'h77, 1'b0);
        host_access(1'b0, 5'd0, 32'd0, 1'b0);
        chk("err_sticky", 64'(err), 64'd1);
        read_burst(64'h10, 1, 64'd8);
        chk_counts();

        // Host write refused while a burst is in flight, then accepted.
        fork
            read_burst(64'h0, 4, 64'd4);
            begin
                repeat (3) @(posedge clk);
                host_access(1'b1, 5'd5, 32'h5555_5555, 1'b1);
            end
        join
        host_access(1'b0, 5'd5, 32'd0, 1'b0);
        host_access(1'b1, 5'd5, 32'h5555_5555, 1'b0);
        host_access(1'b0, 5'd5, 32'd0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            rb = 64'($urandom_range(0, 31)) * 64'd4;
            wb = 64'($urandom_range(0, 31)) * 64'd4;
            if ($urandom_range(0, 7) == 0) rb = rb + 64'd1;
            if ($urandom_range(0, 7) == 0) wb = wb + 64'd2;
            fork
                read_burst(rb, int'($urandom_range(1, 5)), 64'd4);
                write_burst(wb, int'($urandom_range(1, 5)), 64'd4, 32'd0, 1'b1);
            join
            chk_counts();
        end
        for (int i = 0; i < 32; i++) host_access(1'b0, 5'(i), 32'd0, 1'b0);

        // Reset in R_ACK mid-burst.
        @(negedge clk);
        sif.read_enable = 1'b1; sif.read_addr = 64'h8; sif.read_size = 64'd4;
        @(posedge clk);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (sif.read_ready[0] !== 1'b1 && k < 20);
        chk("rst_lat", 64'(k), 64'(READ_LAT + 1));
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_rdw", 64'(rd_words), 64'(m_rd + 1));
        reset = 1'b0;
        #1 chk_outputs_zero();
        sif.read_enable = 1'b0;
        @(posedge clk);
        #1 chk_outputs_zero();
        @(negedge clk) reset = 1'b1;
        m_rd = 0; m_wr = 0; m_err = 1'b0;
        for (int i = 0; i < 32; i++) host_access(1'b0, 5'(i), 32'd0, 1'b0);
        read_burst(64'h4, 2, 64'd4);
        chk_counts();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
